// File: rtl/key_encoder_if.sv
// key_encoder_if: byte-stream handshake carrying encoded key bytes toward the
// host (normally into the UART transmitter).
//   data  : output byte
//   valid : data holds a byte that has not yet been accepted
//   ready : sink accepts data in this cycle (only meaningful while valid=1)
// The master modport is the byte producer and the slave modport is the consumer.
interface key_encoder_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/key_encoder.sv
// key_encoder: converts local key events into VT52 host-bound byte sequences.
// It also answers identify requests with the three-byte reply ESC / IDENT.
//   clk        : system clock
//   clr        : synchronous active-high reset
//   key_code   : key event (00-7F ASCII, 80-86 arrows/PF keys, 87-FF dropped)
//   key_ctrl   : CTRL modifier, sampled together with key_code
//   key_valid  : key_code/key_ctrl are valid
//   key_ready  : encoder can take a key (idle and no identify reply owed)
//   ident_req  : one-cycle pulse requesting an identify reply
//   tx         : registered byte-stream output (data/valid out, ready in)
module key_encoder #(
  parameter logic [7:0] IDENT = 8'h4B
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [7:0]    key_code,
  input  logic          key_ctrl,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic          ident_req,
  key_encoder_if.master tx
);

  // The state value doubles as (index of presented byte + 1).
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_B0   = 2'd1;
  localparam logic [1:0] S_B1   = 2'd2;
  localparam logic [1:0] S_B2   = 2'd3;

  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] SLASH = 8'h2F;

  logic [1:0] state_q, state_d;
  logic [1:0] len_q, len_d;
  logic [7:0] seq_q [3];
  logic [7:0] seq_d [3];
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       pend_q, pend_d;

  // Translation of the presented key into up to two bytes.
  logic [1:0] k_len;
  logic [7:0] k_b0, k_b1;

  always_comb begin
    k_len = 2'd0;
    k_b0  = key_code;
    k_b1  = 8'h00;
    if (!key_code[7]) begin
      k_len = 2'd1;
      // CTRL folds only the 40-7F block onto the control codes.
      if (key_ctrl && key_code[6]) k_b0 = key_code & 8'h1F;
    end else if (key_code <= 8'h86) begin
      k_len = 2'd2;
      k_b0  = ESC;
      case (key_code[2:0])
        3'd0:    k_b1 = 8'h41;  // up    -> A
        3'd1:    k_b1 = 8'h42;  // down  -> B
        3'd2:    k_b1 = 8'h43;  // right -> C
        3'd3:    k_b1 = 8'h44;  // left  -> D
        3'd4:    k_b1 = 8'h50;  // PF1   -> P
        3'd5:    k_b1 = 8'h51;  // PF2   -> Q
        default: k_b1 = 8'h52;  // PF3   -> R
      endcase
    end
    // Codes 87-FF leave k_len at 0: accepted but produce nothing.
  end

  assign key_ready = (state_q == S_IDLE) && !pend_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    seq_d   = seq_q;
    data_d  = data_q;
    valid_d = valid_q;
    // Requests merge into a single sticky flag until the reply is started.
    pend_d  = pend_q | ident_req;

    if (state_q == S_IDLE) begin
      if (pend_q) begin
        seq_d[0] = ESC;
        seq_d[1] = SLASH;
        seq_d[2] = IDENT;
        len_d    = 2'd3;
        pend_d   = 1'b0;
        state_d  = S_B0;
        data_d   = ESC;
        valid_d  = 1'b1;
      end else if (key_valid && (k_len != 2'd0)) begin
        seq_d[0] = k_b0;
        seq_d[1] = k_b1;
        seq_d[2] = 8'h00;
        len_d    = k_len;
        state_d  = S_B0;
        data_d   = k_b0;
        valid_d  = 1'b1;
      end
    end else if (tx.ready) begin
      // valid_q is always set outside S_IDLE, so ready alone completes a byte.
      if (state_q == len_q) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end else begin
        state_d = 2'(state_q + 2'd1);
        data_d  = (state_q == S_B0) ? seq_q[1] : seq_q[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      len_q   <= 2'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_seq
      always_ff @(posedge clk) begin
        if (clr) seq_q[gi] <= 8'h00;
        else     seq_q[gi] <= seq_d[gi];
      end
    end
  endgenerate

  assign tx.data  = data_q;
  assign tx.valid = valid_q;

  // S_B2 is reached only for three-byte sequences (len_q == 3).
  logic unused_b2;
  assign unused_b2 = (state_q == S_B2);

endmodule

// File: doc/key_encoder.md
# key_encoder

Byte-stream producer on the host-bound side of the terminal: it turns local key events into the VT52 byte sequences the host expects and answers identify requests. Single keys go out as plain ASCII or control codes. Arrow and PF keys expand to two-byte escape sequences, and an identify request produces the three-byte `ESC / K` reply. Its output uses the same data/valid/ready byte handshake that the command handler consumes, and normally drives the UART transmitter.

## Interface
Parameters:
- IDENT, default 8'h4B ("K"): third byte of the identify reply.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- key_code  in  8  key event; 8'h00-8'h7F ASCII, 8'h80-8'h86 special keys.
- key_ctrl  in  1  CTRL modifier, sampled with key_code.
- key_valid  in  1  key_code/key_ctrl valid.
- key_ready  out  1  encoder can accept a key; combinational = (state==S_IDLE) && !ident_pending.
- ident_req  in  1  one-cycle pulse: host sent ESC Z, reply required.
- data  out  8  output byte, registered.
- valid  out  1  data valid, registered.
- ready  in  1  downstream accepts data this cycle.

## Operation
- States: S_IDLE, S_B0, S_B1, S_B2. The state register holds the index of the byte currently presented. seq_len (1-3) and seq[0..2] are loaded on sequence start.
- Key accept: key_valid && key_ready at a rising edge.
- Translation at accept:
  - key_ctrl=0, code < 8'h80: 1 byte, the code itself.
  - key_ctrl=1, code in 8'h40-8'h7F: 1 byte, code & 8'h1F.
  - key_ctrl=1, other code < 8'h80: 1 byte, unchanged.
  - 8'h80 up: ESC "A". 8'h81 down: ESC "B". 8'h82 right: ESC "C". 8'h83 left: ESC "D".
  - 8'h84 PF1: ESC "P". 8'h85 PF2: ESC "Q". 8'h86 PF3: ESC "R".
  - key_ctrl is ignored for codes >= 8'h80. ESC = 8'h1B.
  - 8'h87-8'hFF: consumed (key_ready handshake completes), nothing emitted, stays in S_IDLE.
- ident_req sets the sticky flag ident_pending at the edge, in any state. Requests arriving while it is set merge into one reply.
- In S_IDLE with ident_pending=1: load ESC, "/", IDENT (length 3), clear ident_pending, go to S_B0. Pending has priority over keys because key_ready=0.
- ident_req and key_valid in the same cycle with pending previously 0: the key is accepted first and the reply follows it.
- Send states: valid=1 and data=seq[idx]. On valid && ready, advance to the next byte, or return to S_IDLE with valid=0 after the last byte.
- While valid && !ready, data and valid hold stable. valid never drops before acceptance.
- clr (synchronous): data=8'h00, valid=0, state=S_IDLE, ident_pending=0, seq registers 0. A sequence in flight is aborted with no remaining bytes sent. key_ready is 1 in the first cycle after reset.

## Timing
- Key accepted at edge N: valid=1 with the first byte during cycle N+1 (1-cycle latency).
- With ready held high: one byte per cycle. Two-byte sequence: valid high for cycles N+1 and N+2. Three-byte sequence: valid high for cycles N+1 to N+3.
- Last byte accepted at edge M: key_ready=1 in cycle M+1. A key accepted at edge M+1 shows on valid in cycle M+2, so there is exactly one valid=0 bubble between sequences.
- Pending identify reply: served from S_IDLE at the first edge after IDLE is reached. Its first byte is valid the following cycle.
- ready is sampled only while valid=1. ready during valid=0 has no effect.

## Test plan
- Reset then key_code=8'h61, ctrl=0, ready=1: valid one cycle later, data=8'h61, single byte, key_ready high again afterwards.
- key_code=8'h63 with ctrl=1: emits 8'h03. key_code=8'h31 with ctrl=1: emits 8'h31.
- key_code=8'h80, ready held low 3 cycles then high: data=8'h1B stable throughout the stall, then 8'h41. Exactly 2 bytes.
- ident_req pulse while ESC "C" is mid-send, plus a second ident_req pulse: after "C" is sent, one bubble, then 8'h1B, 8'h2F, 8'h4B, emitted once only.
- key_valid and ident_req in the same IDLE cycle with key 8'h85: output ESC "Q", then ESC "/" "K". key_ready stays 0 until the reply is complete.
- clr asserted after the first byte of the identify reply: valid=0 next cycle, no further bytes, ident_pending=0. key_code=8'h90 then consumed with no output.
